imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Registered, parametrised immediate-extension stage for the MIPS datapath, and the successor of the combinational sign extender. It takes an IN_W-bit instruction immediate plus a 2-bit mode and produces an OUT_W-bit operand. The four modes are sign-extend, zero-extend, sign-extend then shift left 2 (branch offset), and load-upper (immediate placed in the top bits). It sits between decode and the ALU operand mux behind a valid/ready handshake, with a 2-entry skid buffer so that full throughput is kept under backpressure.

## Interface
- IN_W, default 16: immediate width; legal range 2..OUT_W-2
- OUT_W, default 32: operand width; must be ≥ IN_W+2 (elaboration-time check, fatal on violation)
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  producer has a transaction
- in_ready  output  1  stage can accept; comes directly from a register (not from logic)
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  extension mode; encodings are in the package
- out_valid  output  1  out_data holds a result
- out_ready  input  1  consumer accepts
- out_data  output  OUT_W  extended operand
- out_mode  output  2  mode that produced out_data, for downstream debug and muxing

## Operation
- Mode rules, with s = in_imm[IN_W-1]:
  - MODE_SEXT (2'b00): {OUT_W-IN_W copies of s, in_imm}
  - MODE_ZEXT (2'b01): {OUT_W-IN_W zeros, in_imm}
  - MODE_SEXT_SL2 (2'b10): SEXT result shifted left 2; the low 2 bits are 0 and the top 2 bits of the sign extension are dropped. This is well defined because OUT_W ≥ IN_W+2.
  - MODE_LUI (2'b11): in_imm in bits [OUT_W-1 : OUT_W-IN_W]; all lower bits 0.
- The extension is computed on the input side, before any register, so both storage entries hold final results.
- Storage consists of a main register (drives the outputs) and a skid register, each holding {valid, data, mode}.
- Handshake signals:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
  - in_ready = ~skid_valid
- The main register loads when ~out_valid | out_ready:
  - it loads from the skid register if skid_valid;
  - otherwise it loads from the input if in_fire;
  - otherwise out_valid goes to 0.
- The skid register captures the input when in_fire and the main register holds a value it cannot drain (out_valid & ~out_ready). It is cleared when its value moves into the main register.
- Effective states:
  - EMPTY (0 valid): in_ready=1, out_valid=0
  - ONE (main valid): in_ready=1
  - FULL (main and skid valid): in_ready=0
- Simultaneous in_fire and out_fire in ONE: the main register is replaced by the new result; state stays ONE.
- Simultaneous in_fire and out_fire in EMPTY: cannot occur, because out_valid=0 in EMPTY.
- While out_valid & ~out_ready, out_data and out_mode hold stable. This is required behaviour and is checked.
- in_imm and in_mode are ignored when in_valid=0. Unknown inputs must not propagate into storage unless in_fire.

## Timing
- Latency: 1 cycle from in_fire to out_valid when the stage is empty.
- Throughput: 1 transaction per cycle with out_ready held high.
- Ordering: results leave in strict acceptance order; nothing is dropped or duplicated.
- Backpressure: after out_ready goes low, at most 1 further transaction is accepted (into the skid register). in_ready falls in the cycle after that capture.
- When out_ready returns high in FULL: the skid entry moves to main in the next cycle, and in_ready is 1 in the same cycle it moves.
- Reset values: out_valid=0, out_data=0, out_mode=0, skid_valid=0, in_ready=1.
- Reset asserted mid-operation discards both entries immediately (asynchronous). The first transaction after reset release may be accepted on the first rising edge.

## Structure
- Package imm_ext_pkg contains:
  - the mode enum/localparams MODE_SEXT, MODE_ZEXT, MODE_SEXT_SL2, MODE_LUI;
  - the 2-bit mode width constant;
  - the default IN_W and OUT_W.
- Sub-module imm_ext_core: purely combinational function of (in_imm, in_mode), parametrised by IN_W and OUT_W. It is instantiated once at the input. It is also reused by the bench as the reference model.
- The top level contains only the skid and main registers and the handshake logic.

## Test plan
- Modes, IN_W=16, OUT_W=32, one transaction each with out_ready=1:
  - in_imm=16'h8004, SEXT → 32'hFFFF8004
  - same immediate, ZEXT → 32'h00008004
  - 16'hFFFF, SEXT_SL2 → 32'hFFFFFFFC
  - 16'h1234, LUI → 32'h12340000
  - each result appears exactly 1 cycle after in_fire.
- Streaming: 8 back-to-back transactions with immediates 0..7, out_ready=1 → 8 consecutive out_valid cycles, with values in order and in_ready never low.
- Backpressure:
  - hold out_ready=0 while pushing 16'h0001, 16'h0002, 16'h0003 (ZEXT) → exactly two are accepted, in_ready=0 on the third, and out_data holds 32'h00000001 stable;
  - then release out_ready → 1, 2, 3 drain in order with no gaps.
- Simultaneous: in state ONE, assert in_fire and out_fire in the same cycle, 50 times → no skid capture, in_ready stays 1, no loss.
- Reset mid-operation: reach FULL, pulse rst_n low asynchronously (not aligned to clk) → out_valid=0 and in_ready=1 immediately, out_data=0, and the stale values never appear after release.
- Parameter sweep: IN_W=8, OUT_W=16, in_imm=8'h80:
  - SEXT → 16'hFF80
  - SEXT_SL2 → 16'hFE00
  - LUI → 16'h8000.

Source files
------------

// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared constants for the immediate-extension stage.
//               Holds the mode encodings, the mode field width and the
//               default immediate/operand widths.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    localparam int MODE_W    = 2;
    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 32;

    localparam logic [MODE_W-1:0] MODE_SEXT     = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ZEXT     = 2'b01;
    localparam logic [MODE_W-1:0] MODE_SEXT_SL2 = 2'b10;
    localparam logic [MODE_W-1:0] MODE_LUI      = 2'b11;

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extender. Produces an OUT_W-bit
//               operand from an IN_W-bit immediate according to the mode:
//               sign-extend, zero-extend, sign-extend + shift left 2, or
//               load-upper.
// Ports       : in_imm   - raw immediate (IN_W)
//               in_mode  - extension mode (MODE_W)
//               out_data - extended operand (OUT_W)
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    output logic [OUT_W-1:0]  out_data
);

    localparam int c_EXT_W = OUT_W - IN_W;

    // The shift-left-2 mode drops the top two sign bits, which is only
    // lossless when at least two extension bits exist.
    generate
        if ((OUT_W < IN_W + 2) || (IN_W < 2)) begin : g_bad_width
            $fatal(1, "imm_ext_core: need 2 <= IN_W and OUT_W >= IN_W+2");
        end
    endgenerate

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_sl2;
    logic [OUT_W-1:0] w_lui;

    assign w_sext = {{c_EXT_W{in_imm[IN_W-1]}}, in_imm};
    assign w_zext = {{c_EXT_W{1'b0}}, in_imm};
    assign w_sl2  = {w_sext[OUT_W-3:0], 2'b00};
    assign w_lui  = {in_imm, {c_EXT_W{1'b0}}};

    always_comb begin
        out_data = w_sext;
        case (in_mode)
            MODE_SEXT:     out_data = w_sext;
            MODE_ZEXT:     out_data = w_zext;
            MODE_SEXT_SL2: out_data = w_sl2;
            MODE_LUI:      out_data = w_lui;
            default:       out_data = w_sext;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pipe
// Description : Registered immediate-extension stage with a valid/ready
//               handshake and a 2-entry skid buffer (main + skid register).
//               Extension happens before storage, so both entries hold
//               final operands. Full throughput is kept under backpressure.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready/in_imm/in_mode    - producer side
//               out_valid/out_ready/out_data/out_mode - consumer side
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [MODE_W-1:0] out_mode
);

    logic [OUT_W-1:0]  w_ext_data;

    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic [MODE_W-1:0] r_out_mode;
    logic              r_skid_valid;
    logic [OUT_W-1:0]  r_skid_data;
    logic [MODE_W-1:0] r_skid_mode;
    logic              r_in_ready;

    logic              w_in_fire;
    logic              w_main_load;
    logic              w_skid_valid_nxt;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_imm   (in_imm),
        .in_mode  (in_mode),
        .out_data (w_ext_data)
    );

    assign w_in_fire   = in_valid & r_in_ready;
    // Main register may take a new value when empty or being drained.
    assign w_main_load = ~r_out_valid | out_ready;

    // Skid stays full until main can drain; it fills only when a new
    // transaction arrives while main is stalled.
    assign w_skid_valid_nxt = r_skid_valid ? ~w_main_load
                                           : (w_in_fire & ~w_main_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_mode   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_mode  <= '0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_main_load) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_mode  <= r_skid_mode;
                end else if (w_in_fire) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_ext_data;
                    r_out_mode  <= in_mode;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end

            // Payload is only written on a real capture so undriven inputs
            // never reach storage.
            if (w_in_fire && !w_main_load) begin
                r_skid_data <= w_ext_data;
                r_skid_mode <= in_mode;
            end

            r_skid_valid <= w_skid_valid_nxt;
            // Registered copy of ~skid_valid so in_ready has no logic
            // in front of the output.
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_mode  = r_out_mode;

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_ext_pipe
// Description : Directed self-checking bench for imm_ext_pipe. A 16->32
//               instance covers modes, streaming, backpressure, concurrent
//               fire and async reset; an 8->16 instance covers the narrow
//               parameter set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;

    logic        in_valid_8;
    logic        in_ready_8;
    logic [7:0]  in_imm_8;
    logic [1:0]  in_mode_8;
    logic        out_valid_8;
    logic        out_ready_8;
    logic [15:0] out_data_8;
    logic [1:0]  out_mode_8;

    int checks;
    int errors;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
    );

    imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_8),
        .in_ready  (in_ready_8),
        .in_imm    (in_imm_8),
        .in_mode   (in_mode_8),
        .out_valid (out_valid_8),
        .out_ready (out_ready_8),
        .out_data  (out_data_8),
        .out_mode  (out_mode_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        checks++; if (out_mode !== 2'b00) begin errors++; $display("FAIL reset_out_mode: got %b expected 00", out_mode); end
        checks++; if (out_valid_8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid_8: got %b expected 0", out_valid_8); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_modes();
        logic [15:0] imms [4];
        logic [1:0]  modes[4];
        logic [31:0] exps [4];
        imms[0] = 16'h8004; modes[0] = MODE_SEXT;     exps[0] = 32'hFFFF8004;
        imms[1] = 16'h8004; modes[1] = MODE_ZEXT;     exps[1] = 32'h00008004;
        imms[2] = 16'hFFFF; modes[2] = MODE_SEXT_SL2; exps[2] = 32'hFFFFFFFC;
        imms[3] = 16'h1234; modes[3] = MODE_LUI;      exps[3] = 32'h12340000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_imm = imms[i]; in_mode = modes[i];
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode%0d_pre_valid: got %b expected 0", i, out_valid); end
            tick();
            in_valid = 1'b0; in_imm = 16'hxxxx; in_mode = 2'bxx;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL mode%0d_data: got %h expected %h", i, out_data, exps[i]); end
            checks++; if (out_mode !== modes[i]) begin errors++; $display("FAIL mode%0d_mode: got %b expected %b", i, out_mode, modes[i]); end
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode%0d_drain: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_imm = 16'(i); in_mode = MODE_ZEXT;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream%0d_in_ready: got %b expected 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream%0d_valid: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== 32'(i)) begin errors++; $display("FAIL stream%0d_data: got %h expected %h", i, out_data, 32'(i)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int accepted;
        accepted = 0;
        out_ready = 1'b0;
        in_mode = MODE_ZEXT;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_imm = 16'(i);
            if (in_ready === 1'b1) accepted++;
            tick();
        end
        checks++; if (accepted !== 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", accepted); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
        // Offered 3 stays pending; output must not move while stalled.
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin errors++; $display("FAIL bp_hold%0d: got valid=%b data=%h expected valid=1 data=00000001", i, out_valid, out_data); end
            tick();
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h2) begin errors++; $display("FAIL bp_drain2: got valid=%b data=%h expected valid=1 data=00000002", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_on_move: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h3) begin errors++; $display("FAIL bp_drain3: got valid=%b data=%h expected valid=1 data=00000003", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b1;
        in_mode = MODE_ZEXT;
        in_valid = 1'b1; in_imm = 16'h0100;
        tick();
        for (int i = 1; i <= 50; i++) begin
            in_imm = 16'(16'h0100 + i);
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL sim%0d_state: got ready=%b valid=%b expected 1 1", i, in_ready, out_valid); end
            tick();
            checks++; if (out_data !== 32'(32'h0100 + i)) begin errors++; $display("FAIL sim%0d_data: got %h expected %h", i, out_data, 32'(32'h0100 + i)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL sim_end: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_mode = MODE_ZEXT;
        in_valid = 1'b1; in_imm = 16'h00AA;
        tick();
        in_imm = 16'h00BB;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_data !== 32'hAA) begin errors++; $display("FAIL ar_full: got ready=%b data=%h expected 0 000000aa", in_ready, out_data); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ar_immediate: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
        checks++; if (out_data !== 32'h0 || out_mode !== 2'b00) begin errors++; $display("FAIL ar_data: got data=%h mode=%b expected 00000000 00", out_data, out_mode); end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_imm = 16'h00CC;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hCC) begin errors++; $display("FAIL ar_first_after: got valid=%b data=%h expected 1 000000cc", out_valid, out_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_stale%0d: got valid=%b data=%h expected valid=0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_param_sweep();
        logic [1:0]  modes[4];
        logic [15:0] exps [4];
        modes[0] = MODE_SEXT;     exps[0] = 16'hFF80;
        modes[1] = MODE_SEXT_SL2; exps[1] = 16'hFE00;
        modes[2] = MODE_LUI;      exps[2] = 16'h8000;
        modes[3] = MODE_ZEXT;     exps[3] = 16'h0080;
        out_ready_8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_8 = 1'b1; in_imm_8 = 8'h80; in_mode_8 = modes[i];
            checks++; if (in_ready_8 !== 1'b1) begin errors++; $display("FAIL p8_%0d_ready: got %b expected 1", i, in_ready_8); end
            tick();
            in_valid_8 = 1'b0;
            checks++; if (out_valid_8 !== 1'b1 || out_data_8 !== exps[i]) begin errors++; $display("FAIL p8_%0d_data: got valid=%b data=%h expected 1 %h", i, out_valid_8, out_data_8, exps[i]); end
            checks++; if (out_mode_8 !== modes[i]) begin errors++; $display("FAIL p8_%0d_mode: got %b expected %b", i, out_mode_8, modes[i]); end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
        in_valid_8 = 1'b0; in_imm_8 = '0; in_mode_8 = '0; out_ready_8 = 1'b0;
        test_reset();
        test_modes();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
